// File: rtl/bta_acc_if.sv
// Stream bundle for bta_acc: run control, operand input and result output.
// The master drives run control, operands and result ready; the slave is the accumulator.
interface bta_acc_if #(
  parameter int DW = 16,
  parameter int LW = 8
);
  logic              i_start;
  logic [LW-1:0]     i_len;
  logic              o_busy;
  logic [DW-1:0]     i_din;
  logic              i_din_vld;
  logic              o_din_rdy;
  logic [DW+LW-1:0]  o_dout;
  logic              o_dout_vld;
  logic              i_dout_rdy;

  modport master (
    output i_start, i_len, i_din, i_din_vld, i_dout_rdy,
    input  o_busy, o_din_rdy, o_dout, o_dout_vld
  );

  modport slave (
    input  i_start, i_len, i_din, i_din_vld, i_dout_rdy,
    output o_busy, o_din_rdy, o_dout, o_dout_vld
  );
endinterface

// File: rtl/bta_acc.sv
// Run accumulator for the lower-bit-rounding approximate adder.
// Low DW_AC bits of each operand are rounded away; the sum is re-aligned on output.
module bta_acc #(
  parameter int DW    = 16,
  parameter int DW_AC = 8,
  parameter int LW    = 8,
  parameter int DWS   = DW + LW
) (
  input logic       i_clk,
  input logic       i_rst_n,
  bta_acc_if.slave  bus
);
  localparam int RW = DW - DW_AC;
  localparam int AW = RW + LW;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC  = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;

  logic [1:0]     state;
  logic [AW-1:0]  acc;
  logic [AW-1:0]  acc_nxt;
  logic [LW-1:0]  cnt;
  logic [DWS-1:0] dout;
  logic           dout_vld;
  logic [RW-1:0]  rnd;

  generate
    if (DW_AC == 0) begin : g_exact
      assign rnd = bus.i_din;
    end else begin : g_round
      logic [RW-1:0] hi;
      logic          half;
      assign hi   = bus.i_din[DW-1:DW_AC];
      assign half = bus.i_din[DW_AC-1];
      // saturate instead of wrapping when the upper part is already all ones
      assign rnd  = (&hi) ? hi : hi + RW'(half);
    end
  endgenerate

  assign acc_nxt = acc + AW'(rnd);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= S_IDLE;
      acc      <= '0;
      cnt      <= '0;
      dout     <= '0;
      dout_vld <= 1'b0;
    end else begin
      unique case (1'b1)
        (state == S_IDLE): begin
          if (bus.i_start) begin
            acc <= '0;
            cnt <= bus.i_len;
            if (bus.i_len != '0) begin
              state <= S_ACC;
            end else begin
              state    <= S_OUT;
              dout     <= '0;
              dout_vld <= 1'b1;
            end
          end
        end
        (state == S_ACC): begin
          if (bus.i_din_vld) begin
            acc <= acc_nxt;
            cnt <= cnt - LW'(1);
            if (cnt == LW'(1)) begin
              state    <= S_OUT;
              dout     <= DWS'(acc_nxt) << DW_AC;
              dout_vld <= 1'b1;
            end
          end
        end
        (state == S_OUT): begin
          if (bus.i_dout_rdy) begin
            state    <= S_IDLE;
            dout_vld <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.o_busy     = (state != S_IDLE);
  assign bus.o_din_rdy  = (state == S_ACC);
  assign bus.o_dout     = dout;
  assign bus.o_dout_vld = dout_vld;
endmodule

// File: tb/tb_bta_acc.sv
// Self-checking bench for bta_acc: rounding, clipping, handshakes, reset.
// Two instances: DW_AC=8 (approximate) and DW_AC=0 (exact).
module tb_bta_acc;
  localparam int DW  = 16;
  localparam int LW  = 8;
  localparam int DWS = DW + LW;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  bta_acc_if #(.DW(DW), .LW(LW)) b0 ();
  bta_acc_if #(.DW(DW), .LW(LW)) b1 ();

  bta_acc #(.DW(DW), .DW_AC(8), .LW(LW)) dut0 (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (b0.slave)
  );

  bta_acc #(.DW(DW), .DW_AC(0), .LW(LW)) dut1 (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (b1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // rounded value: round-half-up of din / 2^ac, limited to the upper-field maximum
  function automatic longint unsigned round_ref(input longint unsigned din, input int ac);
    longint unsigned q, h, mx, r;
    q  = din / (64'd1 << ac);
    h  = (ac == 0) ? 0 : ((din % (64'd1 << ac)) >= (64'd1 << (ac - 1)) ? 1 : 0);
    mx = (64'd1 << (DW - ac)) - 1;
    r  = q + h;
    return (r > mx) ? mx : r;
  endfunction

  task automatic start0(input int len);
    b0.i_start = 1'b1;
    b0.i_len   = LW'(len);
    @(negedge clk);
    b0.i_start = 1'b0;
  endtask

  task automatic send0(input logic [DW-1:0] op, input int gap_max);
    int n;
    int t;
    n = (gap_max > 0) ? $urandom_range(gap_max, 0) : 0;
    repeat (n) @(negedge clk);
    b0.i_din     = op;
    b0.i_din_vld = 1'b1;
    t = 0;
    while (!b0.o_din_rdy && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) begin
      errors++;
      $display("FAIL send0 timeout: din_rdy=%b want 1", b0.o_din_rdy);
    end
    checks++;
    @(negedge clk);
    b0.i_din_vld = 1'b0;
    b0.i_din     = DW'($urandom);
  endtask

  task automatic send1(input logic [DW-1:0] op);
    int t;
    b1.i_din     = op;
    b1.i_din_vld = 1'b1;
    t = 0;
    while (!b1.o_din_rdy && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) begin
      errors++;
      $display("FAIL send1 timeout: din_rdy=%b want 1", b1.o_din_rdy);
    end
    checks++;
    @(negedge clk);
    b1.i_din_vld = 1'b0;
  endtask

  task automatic consume0();
    b0.i_dout_rdy = 1'b1;
    @(negedge clk);
    b0.i_dout_rdy = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    b0.i_start = 0; b0.i_len = '0; b0.i_din = '0;
    b0.i_din_vld = 0; b0.i_dout_rdy = 0;
    b1.i_start = 0; b1.i_len = '0; b1.i_din = '0;
    b1.i_din_vld = 0; b1.i_dout_rdy = 0;
    repeat (3) @(negedge clk);
    if ({b0.o_busy, b0.o_din_rdy, b0.o_dout_vld, b0.o_dout} !== '0) begin
      errors++;
      $display("FAIL reset outputs: got %b/%b/%b/%h want all 0",
               b0.o_busy, b0.o_din_rdy, b0.o_dout_vld, b0.o_dout);
    end
    checks++;
    rst_n = 1'b1;
    @(negedge clk);
    if (b0.o_busy !== 1'b0 || b1.o_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset idle: busy0=%b busy1=%b want 0", b0.o_busy, b1.o_busy);
    end
    checks++;
  endtask

  task automatic test_run3();
    start0(3);
    if (b0.o_din_rdy !== 1'b1 || b0.o_busy !== 1'b1) begin
      errors++;
      $display("FAIL run3 acc state: rdy=%b busy=%b want 1 1", b0.o_din_rdy, b0.o_busy);
    end
    checks++;
    send0(16'h0180, 0);
    send0(16'h0280, 0);
    if (b0.o_dout_vld !== 1'b0) begin
      errors++;
      $display("FAIL run3 early vld: got %b want 0", b0.o_dout_vld);
    end
    checks++;
    send0(16'h007F, 0);
    if (b0.o_dout_vld !== 1'b1 || b0.o_dout !== 24'h000500) begin
      errors++;
      $display("FAIL run3 result: vld=%b dout=%h want 1 000500", b0.o_dout_vld, b0.o_dout);
    end
    checks++;
    consume0();
  endtask

  task automatic test_clip();
    start0(1);
    send0(16'hFF80, 0);
    if (b0.o_dout_vld !== 1'b1 || b0.o_dout !== 24'h00FF00) begin
      errors++;
      $display("FAIL clip result: vld=%b dout=%h want 1 00ff00", b0.o_dout_vld, b0.o_dout);
    end
    checks++;
    consume0();
  endtask

  task automatic test_zero_len();
    b0.i_din = 16'h7F00;
    b0.i_din_vld = 1'b1;
    start0(0);
    if (b0.o_dout_vld !== 1'b1 || b0.o_dout !== '0 || b0.o_din_rdy !== 1'b0) begin
      errors++;
      $display("FAIL zero_len result: vld=%b dout=%h rdy=%b want 1 000000 0",
               b0.o_dout_vld, b0.o_dout, b0.o_din_rdy);
    end
    checks++;
    consume0();
    b0.i_din_vld = 1'b0;
    if (b0.o_busy !== 1'b0 || b0.o_dout !== '0) begin
      errors++;
      $display("FAIL zero_len idle: busy=%b dout=%h want 0 000000", b0.o_busy, b0.o_dout);
    end
    checks++;
  endtask

  task automatic test_backpressure();
    start0(1);
    send0(16'h0300, 0);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        b0.i_start = 1'b1;
        b0.i_len   = 8'd5;
      end
      @(negedge clk);
      b0.i_start = 1'b0;
      if (b0.o_dout_vld !== 1'b1 || b0.o_dout !== 24'h000300 || b0.o_din_rdy !== 1'b0) begin
        errors++;
        $display("FAIL backpressure hold %0d: vld=%b dout=%h rdy=%b want 1 000300 0",
                 i, b0.o_dout_vld, b0.o_dout, b0.o_din_rdy);
      end
      checks++;
    end
    b0.i_dout_rdy = 1'b1;
    b0.i_start    = 1'b1;
    b0.i_len      = 8'd2;
    @(negedge clk);
    b0.i_dout_rdy = 1'b0;
    b0.i_start    = 1'b0;
    if (b0.o_dout_vld !== 1'b0 || b0.o_busy !== 1'b0 || b0.o_dout !== 24'h000300) begin
      errors++;
      $display("FAIL backpressure release: vld=%b busy=%b dout=%h want 0 0 000300",
               b0.o_dout_vld, b0.o_busy, b0.o_dout);
    end
    checks++;
  endtask

  task automatic test_reset_mid_run();
    start0(4);
    send0(16'h0500, 0);
    send0(16'h0500, 0);
    rst_n = 1'b0;
    #1;
    if ({b0.o_busy, b0.o_din_rdy, b0.o_dout_vld, b0.o_dout} !== '0) begin
      errors++;
      $display("FAIL midrun reset: busy=%b rdy=%b vld=%b dout=%h want all 0",
               b0.o_busy, b0.o_din_rdy, b0.o_dout_vld, b0.o_dout);
    end
    checks++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start0(2);
    send0(16'h0100, 0);
    send0(16'h0100, 0);
    if (b0.o_dout_vld !== 1'b1 || b0.o_dout !== 24'h000200) begin
      errors++;
      $display("FAIL midrun rerun: vld=%b dout=%h want 1 000200", b0.o_dout_vld, b0.o_dout);
    end
    checks++;
    consume0();
  endtask

  task automatic test_max_run();
    start0(255);
    for (int i = 0; i < 255; i++) send0(16'hFFFF, 2);
    if (b0.o_dout_vld !== 1'b1 || b0.o_dout !== 24'hFE0100) begin
      errors++;
      $display("FAIL max_run result: vld=%b dout=%h want 1 fe0100", b0.o_dout_vld, b0.o_dout);
    end
    checks++;
    consume0();
  endtask

  task automatic test_exact();
    b1.i_start = 1'b1;
    b1.i_len   = 8'd3;
    @(negedge clk);
    b1.i_start = 1'b0;
    send1(16'd1);
    send1(16'd2);
    send1(16'd3);
    if (b1.o_dout_vld !== 1'b1 || b1.o_dout !== 24'd6) begin
      errors++;
      $display("FAIL exact result: vld=%b dout=%h want 1 000006", b1.o_dout_vld, b1.o_dout);
    end
    checks++;
    b1.i_dout_rdy = 1'b1;
    @(negedge clk);
    b1.i_dout_rdy = 1'b0;
  endtask

  task automatic test_random();
    for (int run = 0; run < 6; run++) begin
      int len;
      longint unsigned sum;
      logic [DW-1:0] op;
      logic [DWS-1:0] exp;
      len = $urandom_range(20, 1);
      sum = 0;
      start0(len);
      for (int k = 0; k < len; k++) begin
        op  = DW'($urandom);
        sum += round_ref(op, 8);
        send0(op, 3);
      end
      exp = DWS'(sum * 256);
      repeat ($urandom_range(3, 0)) @(negedge clk);
      if (b0.o_dout_vld !== 1'b1 || b0.o_dout !== exp) begin
        errors++;
        $display("FAIL random run %0d: vld=%b dout=%h want 1 %h", run, b0.o_dout_vld, b0.o_dout, exp);
      end
      checks++;
      consume0();
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_run3();
    test_clip();
    test_zero_len();
    test_backpressure();
    test_reset_mid_run();
    test_max_run();
    test_exact();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
